// File: rtl/snake_engine.sv
// snake_engine: single-player snake game core on a 40x40 board.
// Keeps the head position, a 100-slot direction list (head toward tail),
// the apple, a hearts countdown and the stage FSM. All of it is packed
// into the registered snake_data bus that the VGA renderer reads.
//
// Handshake note: there is no valid/ready pair. iSTART is a single-cycle
// pulse sampled on every rising edge. snake_data is a plain registered
// level: it changes on the edge that ends a move-tick cycle (or on a
// start/reset edge) and holds its value at all other times.
module snake_engine #(
  parameter int TICK_DIV    = 2500000,
  parameter int HEART_TICKS = 4,
  parameter int START_LEN   = 2,
  parameter int MAX_LEN     = 49
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iSTART,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  output logic [487:0] snake_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } stage_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] HEART_L   = 32'(HEART_TICKS);
  localparam logic [31:0] START_L   = 32'(START_LEN);
  localparam logic [31:0] MAX_L     = 32'(MAX_LEN);
  localparam logic [10:0] HEAD_INIT = 11'd820;
  localparam logic [10:0] APPLE_INIT = 11'd425;
  localparam logic [6:0]  HEARTS_FULL = 7'd100;

  stage_t       r_stage, w_stage_next;
  logic [10:0]  r_head1, w_head1_next;
  logic [31:0]  r_len1, w_len1_next;
  logic [199:0] r_dirs, w_dirs_next;
  logic [1:0]   r_cur_dir, w_cur_dir_next;
  logic [1:0]   r_pend_dir, w_pend_dir_next;
  logic [10:0]  r_apple, w_apple_next;
  logic [6:0]   r_hearts, w_hearts_next;
  logic [31:0]  r_tick_cnt, w_tick_cnt_next;
  logic [31:0]  r_heart_cnt, w_heart_cnt_next;
  logic [15:0]  r_lfsr, w_lfsr_next;

  logic [1:0]   w_req;
  logic         w_req_valid;
  logic [1:0]   w_pend;
  logic [10:0]  w_row, w_col;
  logic         w_wall;
  logic [10:0]  w_new_head;
  logic [10:0]  w_rand;
  logic [10:0]  w_apple_pick;
  logic [31:0]  w_hc_inc;

  // Button decode: highest-priority request, reversals dropped, else keep.
  always_comb begin
    w_req       = r_pend_dir;
    w_req_valid = 1'b1;
    if (up)         w_req = 2'b00;
    else if (down)  w_req = 2'b10;
    else if (left)  w_req = 2'b11;
    else if (right) w_req = 2'b01;
    else            w_req_valid = 1'b0;
    w_pend = (w_req_valid && (w_req != (r_cur_dir ^ 2'b10))) ? w_req : r_pend_dir;
  end

  // Geometry: wall test and candidate head for the pending direction.
  always_comb begin
    w_row      = r_head1 / 11'd40;
    w_col      = r_head1 % 11'd40;
    w_wall     = 1'b0;
    w_new_head = r_head1;
    case (w_pend)
      2'b00: begin w_wall = (w_row == 11'd0);  w_new_head = r_head1 - 11'd40; end
      2'b01: begin w_wall = (w_col == 11'd39); w_new_head = r_head1 + 11'd1;  end
      2'b10: begin w_wall = (w_row == 11'd39); w_new_head = r_head1 + 11'd40; end
      default: begin w_wall = (w_col == 11'd0); w_new_head = r_head1 - 11'd1; end
    endcase
    w_rand       = 11'(r_lfsr % 16'd1600);
    w_apple_pick = w_rand;
    if (w_rand == w_new_head)
      w_apple_pick = (w_rand == 11'd1599) ? 11'd0 : w_rand + 11'd1;
    w_hc_inc = r_heart_cnt + 32'd1;
  end

  // Stage FSM next-state and game-state update; everything holds by default.
  always_comb begin
    w_stage_next     = r_stage;
    w_head1_next     = r_head1;
    w_len1_next      = r_len1;
    w_dirs_next      = r_dirs;
    w_cur_dir_next   = r_cur_dir;
    w_pend_dir_next  = r_pend_dir;
    w_apple_next     = r_apple;
    w_hearts_next    = r_hearts;
    w_tick_cnt_next  = r_tick_cnt;
    w_heart_cnt_next = r_heart_cnt;
    w_lfsr_next      = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    case (r_stage)
      S_IDLE: begin
        if (iSTART) begin
          w_stage_next     = S_PLAY;
          w_head1_next     = HEAD_INIT;
          w_len1_next      = START_L;
          w_dirs_next      = {100{2'b01}};
          w_cur_dir_next   = 2'b11;
          w_pend_dir_next  = 2'b11;
          w_apple_next     = APPLE_INIT;
          w_hearts_next    = HEARTS_FULL;
          w_tick_cnt_next  = '0;
          w_heart_cnt_next = '0;
        end
      end
      S_PLAY: begin
        w_pend_dir_next = w_pend;
        w_tick_cnt_next = r_tick_cnt + 32'd1;
        if (r_tick_cnt == TICK_LAST) begin
          w_tick_cnt_next = '0;
          if (w_wall) begin
            w_stage_next = S_OVER;
          end else begin
            w_head1_next   = w_new_head;
            w_dirs_next    = {r_dirs[197:0], w_pend ^ 2'b10};
            w_cur_dir_next = w_pend;
            if (w_new_head == r_apple) begin
              w_len1_next   = (r_len1 >= MAX_L) ? MAX_L : r_len1 + 32'd1;
              w_hearts_next = HEARTS_FULL;
              w_apple_next  = w_apple_pick;
            end else if (w_hc_inc >= HEART_L) begin
              w_heart_cnt_next = '0;
              if (r_hearts <= 7'd1) begin
                w_hearts_next = 7'd0;
                w_stage_next  = S_OVER;
              end else begin
                w_hearts_next = r_hearts - 7'd1;
              end
            end else begin
              w_heart_cnt_next = w_hc_inc;
            end
          end
        end
      end
      S_OVER: begin
        if (iSTART) w_stage_next = S_IDLE;
      end
      default: w_stage_next = S_IDLE;
    endcase
  end

  // State registers with synchronous reset to the power-on game state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_stage     <= S_IDLE;
      r_head1     <= HEAD_INIT;
      r_len1      <= START_L;
      r_dirs      <= {100{2'b01}};
      r_cur_dir   <= 2'b11;
      r_pend_dir  <= 2'b11;
      r_apple     <= APPLE_INIT;
      r_hearts    <= HEARTS_FULL;
      r_tick_cnt  <= '0;
      r_heart_cnt <= '0;
      r_lfsr      <= 16'hACE1;
    end else begin
      r_stage     <= w_stage_next;
      r_head1     <= w_head1_next;
      r_len1      <= w_len1_next;
      r_dirs      <= w_dirs_next;
      r_cur_dir   <= w_cur_dir_next;
      r_pend_dir  <= w_pend_dir_next;
      r_apple     <= w_apple_next;
      r_hearts    <= w_hearts_next;
      r_tick_cnt  <= w_tick_cnt_next;
      r_heart_cnt <= w_heart_cnt_next;
      r_lfsr      <= w_lfsr_next;
    end
  end

  // Renderer bus: straight concatenation of registers, so it is registered.
  always_comb begin
    snake_data = {32'(r_hearts), 32'(r_apple), 32'd0, 32'd0, 32'(r_stage),
                  32'd0, r_len1, 32'd0, 32'(r_head1), r_dirs};
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter TICK_DIV, default 2500000, clocks per move tick (10 moves/s at 25 MHz).
REQ-002 Parameter HEART_TICKS, default 4, move ticks per heartsTimer decrement.
REQ-003 Parameter START_LEN, default 2, body length loaded on game start.
REQ-004 Parameter MAX_LEN, default 49, length saturation value.
REQ-005 iCLK  in  1  single clock; all logic on rising edge.
REQ-006 iRST  in  1  reset, synchronous, active-high.
REQ-007 iSTART  in  1  single-cycle start/acknowledge pulse.
REQ-008 up, down, left, right  in  1 each  level-sensitive direction requests, already synchronous to iCLK.
REQ-009 snake_data  out  488  registered game-state bus consumed by the VGA renderer.

Function
REQ-010 snake_data fields: [199:0] direction list (slot k at [2k+1:2k]); [231:200] head1position; [263:232] head2position; [295:264] length1; [327:296] length2; [359:328] stage; [391:360] head1 index; [423:392] head2 index; [455:424] applePosition; [487:456] heartsTimer.
REQ-011 Board is 40x40; position = 40*row + col, range 0..1599.
REQ-012 Direction code: 00 up (-40), 01 right (+1), 10 down (+40), 11 left (-1); slot k gives the step from segment k to segment k+1, toward the tail.
REQ-013 head1 index, head2 index, head2position, length2: constant 0.
REQ-014 Stage FSM: IDLE (stage 0), PLAY (stage 2), OVER (stage 3); no other values.
REQ-015 IDLE -> PLAY on iSTART; OVER -> IDLE on iSTART; iSTART ignored in PLAY.
REQ-016 Entering PLAY: head1position 820, length1 START_LEN, move direction 11, all 100 slots 01, applePosition 425, heartsTimer 100, tick and heart counters 0.
REQ-017 Tick counter runs only in PLAY; counts 0..TICK_DIV-1; move tick asserted on cycle where it wraps.
REQ-018 Pending direction latched every PLAY cycle from buttons, priority up>down>left>right; request equal to current move direction XOR 2'b10 (reversal) ignored; no button -> unchanged.
REQ-019 On move tick, wall check with pending direction: row 0 up, row 39 down, col 0 left, col 39 right -> stage OVER, position/list/length frozen.
REQ-020 Otherwise on move tick: head1position steps per REQ-012; direction list shifts up one slot (slot k <- slot k-1, slot 99 dropped); slot 0 <- pending XOR 2'b10; current direction <- pending.
REQ-021 Apple eaten when new head1position equals applePosition: length1 <- min(length1+1, MAX_LEN); heartsTimer <- 100; applePosition <- LFSR mod 1600, or (that +1) mod 1600 if equal to new head.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11, free-running every clock in all stages.
REQ-023 Heart counter increments per non-eating move tick; at HEART_TICKS it clears and heartsTimer decrements by 1.
REQ-024 heartsTimer reaching 0 -> stage OVER on the same update; never wraps below 0.
REQ-025 Eat and heart decrement on the same tick: eat wins, heartsTimer = 100.
REQ-026 Wall hit takes priority over eating and heart decrement on the same tick.
REQ-027 snake_data updates one cycle after the tick cycle; stable between ticks.
REQ-028 In IDLE and OVER all fields except stage and LFSR hold their values.

Reset
REQ-029 iRST: stage IDLE, head1position 820, length1 START_LEN, all slots 01, applePosition 425, heartsTimer 100, counters 0, LFSR 16'hACE1, snake_data reflecting these values the cycle after reset.
REQ-030 iRST dominates iSTART and mid-game state; asserted in any cycle it yields REQ-029 state next cycle.

Verification (TICK_DIV=4, HEART_TICKS=4)
REQ-031 Reset, iSTART, no buttons, one tick -> stage 2, head1position 819, slot0 01, length1 2.
REQ-032 PLAY, press right only (reversal) -> direction stays left; after tick head1position 819.
REQ-033 Press up, hold 20 ticks from 820 -> position 20 at tick 20; tick 21 -> stage 3, position 20.
REQ-034 Force apple 818, two left ticks -> length1 3, heartsTimer 100, applePosition != 818.
REQ-035 No eating for 400 ticks on safe path -> heartsTimer 0, stage 3 at tick 400.
REQ-036 iRST mid-PLAY with up held -> next cycle stage 0, head1position 820, heartsTimer 100.
